// File: rtl/squeeze_fifo_drain.sv
// Purpose: pops the squeeze 3x3 / 1x1 FIFOs in lockstep and serialises each 96+96 bit pair into four 48-bit beats.
// Latency: pop to first beat is 2 cycles (standard-read FIFOs) or 1 cycle with SQZ_DRAIN_FWFT_EN defined (FWFT FIFOs).
// Backpressure: m_ready_i low holds the current beat stable in EMIT; no FIFO pop happens until all four beats leave.
module squeeze_fifo_drain (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        start_i,
  input  logic [10:0] word_count_i,
  input  logic [95:0] fifo_squeeze_3x3_rd_data_i,
  output logic        fifo_squeeze_3x3_rd_en_o,
  input  logic        fifo_squeeze_3x3_empty_i,
  input  logic [95:0] fifo_squeeze_1x1_rd_data_i,
  output logic        fifo_squeeze_1x1_rd_en_o,
  input  logic        fifo_squeeze_1x1_empty_i,
  output logic [47:0] m_data_o,
  output logic        m_valid_o,
  output logic        m_last_o,
  input  logic        m_ready_i,
  output logic        busy_o,
  output logic        done_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_LOAD = 2'd2,
    S_EMIT = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [10:0] r_cnt_max;
  logic [10:0] r_pair_cnt;
  logic [1:0]  r_beat;
  logic [95:0] r_buf3;
  logic [95:0] r_buf1;
  logic        r_done;

  logic        w_start_ok;
  logic        w_pop;
  logic        w_capture;
  logic        w_valid;
  logic        w_hs;
  logic        w_last_pair;
  logic        w_pair_end;
  logic        w_frame_end;
  logic [47:0] w_beat_dat;

  assign w_last_pair = (r_pair_cnt == r_cnt_max);
  assign w_pair_end  = w_hs && (r_beat == 2'd3);
  assign w_frame_end = w_pair_end && w_last_pair;

  // Next-state and combinational outputs; the pop depends only on state and both empties.
  always_comb begin
    w_state_nxt = r_state;
    w_start_ok  = 1'b0;
    w_pop       = 1'b0;
    w_capture   = 1'b0;
    w_valid     = 1'b0;
    w_hs        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start_i) begin
          w_start_ok  = 1'b1;
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (!fifo_squeeze_3x3_empty_i && !fifo_squeeze_1x1_empty_i) begin
          w_pop = 1'b1;
`ifdef SQZ_DRAIN_FWFT_EN
          // FWFT data is already on the bus, so capture with the pop and skip LOAD.
          w_capture   = 1'b1;
          w_state_nxt = S_EMIT;
`else
          w_state_nxt = S_LOAD;
`endif
        end
      end
`ifndef SQZ_DRAIN_FWFT_EN
      S_LOAD: begin
        // Standard-read FIFO data appears the cycle after the pop.
        w_capture   = 1'b1;
        w_state_nxt = S_EMIT;
      end
`endif
      S_EMIT: begin
        w_valid = 1'b1;
        w_hs    = m_ready_i;
        if (m_ready_i && (r_beat == 2'd3)) begin
          w_state_nxt = w_last_pair ? S_IDLE : S_WAIT;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Frame length and pair counter; a start while busy never reaches here.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_cnt_max  <= 11'd0;
      r_pair_cnt <= 11'd0;
    end else if (w_start_ok) begin
      r_cnt_max  <= word_count_i;
      r_pair_cnt <= 11'd0;
    end else if (w_pair_end && !w_last_pair) begin
      r_pair_cnt <= r_pair_cnt + 11'd1;
    end
  end

  // Beat index: cleared at start and on every pair capture, steps on each handshake.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_beat <= 2'd0;
    end else if (w_start_ok || w_capture) begin
      r_beat <= 2'd0;
    end else if (w_hs) begin
      r_beat <= r_beat + 2'd1;
    end
  end

  // Pair buffers hold the popped words for the whole EMIT phase.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_buf3 <= 96'd0;
      r_buf1 <= 96'd0;
    end else if (w_capture) begin
      r_buf3 <= fifo_squeeze_3x3_rd_data_i;
      r_buf1 <= fifo_squeeze_1x1_rd_data_i;
    end
  end

  // Completion pulse lands the cycle after the final handshake, with the return to IDLE.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_done <= 1'b0;
    end else begin
      r_done <= w_frame_end;
    end
  end

  // Beat select: 3x3 lower, 3x3 upper, 1x1 lower, 1x1 upper.
  always_comb begin
    w_beat_dat = 48'd0;
    case (r_beat)
      2'd0:    w_beat_dat = r_buf3[47:0];
      2'd1:    w_beat_dat = r_buf3[95:48];
      2'd2:    w_beat_dat = r_buf1[47:0];
      default: w_beat_dat = r_buf1[95:48];
    endcase
  end

  assign fifo_squeeze_3x3_rd_en_o = w_pop;
  assign fifo_squeeze_1x1_rd_en_o = w_pop;
  assign m_valid_o                = w_valid;
  assign m_data_o                 = w_valid ? w_beat_dat : 48'd0;
  assign m_last_o                 = w_valid && (r_beat == 2'd3) && w_last_pair;
  assign busy_o                   = (r_state != S_IDLE);
  assign done_o                   = r_done;

endmodule

// File: tb/tb_squeeze_fifo_drain.sv
// Bench for squeeze_fifo_drain: models both FIFOs as queues and predicts the beat stream from popped pairs.
// Builds with or without SQZ_DRAIN_FWFT_EN to match the RTL build.
module tb_squeeze_fifo_drain;

`ifdef SQZ_DRAIN_FWFT_EN
  localparam int PER_PAIR = 5;
  localparam bit FWFT = 1'b1;
`else
  localparam int PER_PAIR = 6;
  localparam bit FWFT = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        start_i;
  logic [10:0] word_count_i;
  logic [95:0] d3, d1;
  logic        rd3, rd1;
  logic        e3, e1;
  logic [47:0] m_data_o;
  logic        m_valid_o, m_last_o, m_ready_i, busy_o, done_o;

  always #5 clk_i = ~clk_i;

  squeeze_fifo_drain dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .start_i(start_i), .word_count_i(word_count_i),
    .fifo_squeeze_3x3_rd_data_i(d3), .fifo_squeeze_3x3_rd_en_o(rd3), .fifo_squeeze_3x3_empty_i(e3),
    .fifo_squeeze_1x1_rd_data_i(d1), .fifo_squeeze_1x1_rd_en_o(rd1), .fifo_squeeze_1x1_empty_i(e1),
    .m_data_o(m_data_o), .m_valid_o(m_valid_o), .m_last_o(m_last_o), .m_ready_i(m_ready_i),
    .busy_o(busy_o), .done_o(done_o)
  );

  logic [95:0] q3[$];
  logic [95:0] q1[$];
  logic [47:0] expq[$];
  int checks = 0;
  int failures = 0;

  // Reference model state
  logic        busy_m = 1'b0;
  logic        done_m = 1'b0;
  int          frame_len = 0;
  int          hs_in_frame = 0;
  int          pops = 0;
  logic        prev_stall = 1'b0;
  logic [47:0] prev_data = 48'd0;
  logic        saw_done = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic update_outs();
    e3 = (q3.size() == 0);
    e1 = (q1.size() == 0);
    if (FWFT) begin
      d3 = e3 ? 96'd0 : q3[0];
      d1 = e1 ? 96'd0 : q1[0];
    end
  endtask

  task automatic push_pair(input logic [95:0] a3, input logic [95:0] a1);
    q3.push_back(a3);
    q1.push_back(a1);
    update_outs();
  endtask

  function automatic logic [95:0] rnd96();
    return {$urandom, $urandom, $urandom};
  endfunction

  // One clock: check at negedge, advance the model, then update FIFOs just after posedge.
  task automatic tick();
    logic        hs, fin, rd;
    logic [95:0] p3, p1;
    @(negedge clk_i);
    chk("busy", busy_o, busy_m);
    chk("done", done_o, done_m);
    chk("pop_lockstep", rd3, rd1);
    chk("pop_when_empty", rd3 && (e3 || e1), 1'b0);
    chk("pop_while_valid", rd3 && m_valid_o, 1'b0);
    if (prev_stall) begin
      chk("stall_valid", m_valid_o, 1'b1);
      chk("stall_data", m_data_o, prev_data);
    end
    if (!m_valid_o) chk("last_without_valid", m_last_o, 1'b0);
    hs = m_valid_o && m_ready_i;
    fin = 1'b0;
    if (hs) begin
      hs_in_frame++;
      fin = (hs_in_frame == frame_len);
      if (expq.size() == 0) chk("beat_unexpected", 1'b1, 1'b0);
      else chk("beat_data", m_data_o, expq.pop_front());
      chk("last_flag", m_last_o, fin);
    end
    saw_done = done_o;
    prev_stall = m_valid_o && !m_ready_i;
    prev_data = m_data_o;
    rd = rd3;
    done_m = 1'b0;
    if (start_i && !busy_m && rst_n_i) begin
      busy_m = 1'b1;
      frame_len = 4 * (int'(word_count_i) + 1);
      hs_in_frame = 0;
      pops = 0;
    end
    if (fin) begin
      busy_m = 1'b0;
      done_m = 1'b1;
    end
    @(posedge clk_i);
    #1;
    if (rd && q3.size() > 0 && q1.size() > 0) begin
      p3 = q3.pop_front();
      p1 = q1.pop_front();
      pops++;
      expq.push_back(p3[47:0]);
      expq.push_back(p3[95:48]);
      expq.push_back(p1[47:0]);
      expq.push_back(p1[95:48]);
      if (!FWFT) begin
        d3 = p3;
        d1 = p1;
      end
    end
    update_outs();
  endtask

  task automatic run_frame(input logic [10:0] wc, input bit rnd_ready, input int budget, output int elapsed);
    int n;
    word_count_i = wc;
    start_i = 1'b1;
    m_ready_i = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    tick();
    start_i = 1'b0;
    n = 1;
    while (!saw_done && n < budget) begin
      if (rnd_ready) m_ready_i = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    if (!saw_done) chk("frame_timeout", 1'b0, 1'b1);
    elapsed = n - 1;
  endtask

  task automatic model_reset();
    busy_m = 1'b0;
    done_m = 1'b0;
    hs_in_frame = 0;
    frame_len = 0;
    prev_stall = 1'b0;
    expq.delete();
  endtask

  initial begin
    int el;
    int guard;
    rst_n_i = 1'b0;
    start_i = 1'b0;
    m_ready_i = 1'b0;
    word_count_i = 11'd0;
    d3 = 96'd0;
    d1 = 96'd0;
    update_outs();
    #2;
    chk("rst_valid", m_valid_o, 1'b0);
    chk("rst_data", m_data_o, 48'd0);
    chk("rst_last", m_last_o, 1'b0);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_done", done_o, 1'b0);
    chk("rst_rd3", rd3, 1'b0);
    chk("rst_rd1", rd1, 1'b0);
    repeat (2) @(posedge clk_i);
    #1;
    rst_n_i = 1'b1;
    tick();

    // Single pair, ready high
    push_pair({48'h0A0A_0A0A_0A0A, 48'h0B0B_0B0B_0B0B}, {48'h1111_2222_3333, 48'h4444_5555_6666});
    run_frame(11'd0, 1'b0, 50, el);
    chk("single_pops", pops, 1);
    chk("single_cycles", el, PER_PAIR + 1);
    chk("single_drained", expq.size(), 0);
    tick();

    // Four pairs, random backpressure
    for (int i = 0; i < 4; i++) push_pair(rnd96(), rnd96());
    run_frame(11'd3, 1'b1, 400, el);
    chk("multi_pops", pops, 4);
    chk("multi_beats", hs_in_frame, 16);
    chk("multi_drained", expq.size(), 0);
    m_ready_i = 1'b1;
    tick();

    // Only the 3x3 FIFO holds data: no pop on either side
    word_count_i = 11'd0;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    q3.push_back(rnd96());
    update_outs();
    repeat (20) tick();
    chk("asym_no_pop", pops, 0);
    chk("asym_still_busy", busy_o, 1'b1);
    q1.push_back(rnd96());
    update_outs();
    guard = 0;
    while (!saw_done && guard < 40) begin
      tick();
      guard++;
    end
    chk("asym_done_seen", saw_done, 1'b1);
    chk("asym_pops", pops, 1);
    tick();

    // Start while busy is ignored
    for (int i = 0; i < 4; i++) push_pair(rnd96(), rnd96());
    word_count_i = 11'd1;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    repeat (3) tick();
    word_count_i = 11'd9;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    guard = 0;
    while (!saw_done && guard < 60) begin
      tick();
      guard++;
    end
    chk("busy_start_done", saw_done, 1'b1);
    chk("busy_start_pops", pops, 2);
    chk("busy_start_left", q3.size(), 2);
    q3.delete();
    q1.delete();
    update_outs();
    tick();

    // Reset while beat 2 of the first pair is presented
    push_pair(rnd96(), rnd96());
    push_pair(rnd96(), rnd96());
    word_count_i = 11'd1;
    start_i = 1'b1;
    m_ready_i = 1'b1;
    tick();
    start_i = 1'b0;
    guard = 0;
    while (hs_in_frame < 2 && guard < 30) begin
      tick();
      guard++;
    end
    chk("rst_mid_reach_beat2", m_valid_o, 1'b1);
    rst_n_i = 1'b0;
    #1;
    chk("rst_mid_valid", m_valid_o, 1'b0);
    chk("rst_mid_data", m_data_o, 48'd0);
    chk("rst_mid_last", m_last_o, 1'b0);
    chk("rst_mid_busy", busy_o, 1'b0);
    chk("rst_mid_done", done_o, 1'b0);
    chk("rst_mid_rd", rd3 || rd1, 1'b0);
    model_reset();
    repeat (2) tick();
    rst_n_i = 1'b1;
    chk("rst_mid_fifo_kept", q3.size(), 1);
    run_frame(11'd0, 1'b0, 50, el);
    chk("rst_after_pops", pops, 1);
    chk("rst_after_drained", expq.size(), 0);
    tick();

    // Maximum frame: 2048 pairs
    for (int i = 0; i < 2048; i++) push_pair(rnd96(), rnd96());
    run_frame(11'd2047, 1'b0, 13000, el);
    chk("max_beats", hs_in_frame, 8192);
    chk("max_pops", pops, 2048);
    chk("max_cycles", el, PER_PAIR * 2048 + 1);
    chk("max_drained", expq.size(), 0);
    tick();
    chk("max_idle", busy_o, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
